// File: rtl/pipeline_sequencer_pkg.sv
// Shared encodings for the MIPS pipeline run/step/halt sequencer.
package pipeline_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] CMD_RUN      = 2'b00;
    localparam logic [1:0] CMD_STEP     = 2'b01;
    localparam logic [1:0] CMD_HALT_REQ = 2'b10;
    localparam logic [1:0] CMD_CLEAR    = 2'b11;

    localparam int DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/pipeline_sequencer_load_use_detector.sv
// Load-use hazard detect: the load in EX writes a register that the instruction in ID reads.
module load_use_detector (
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic [4:0] i_ex_rt,
    input  logic       i_ex_mem_rd,
    output logic       stall
);

    // $0 is hardwired to zero, so a load into it never creates a dependency.
    assign stall = i_ex_mem_rd && (i_ex_rt != 5'd0) &&
                   ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer and hazard scheduler for the 5-stage MIPS pipeline.
// Optional RUN watchdog is built when PIPELINE_SEQUENCER_WDOG_EN is defined.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | pipe frozen, waiting for RUN or STEP
// RUN       | free-running; HALT_REQ stops, HALT in ID starts drain
// STEP      | one enabled cycle, then back to IDLE (or drain on HALT)
// DRAIN     | front end frozen, EX/MEM/WB retire for DRAIN_CYCLES
// HALTED    | pipe frozen after HALT; CLEAR returns to IDLE
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int NBITS        = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
`ifdef PIPELINE_SEQUENCER_WDOG_EN
    ,
    parameter int WDOG_LIMIT   = 1000000
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_ex_mem_rd,
    input  logic             i_id_jump,
    input  logic             i_id_branch_taken,
    input  logic             i_id_halt,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_hazard_detected,
    output logic             o_pipe_en,
    output logic [2:0]       o_state,
    output logic             o_halted,
`ifdef PIPELINE_SEQUENCER_WDOG_EN
    output logic             o_wdog_trip,
`endif
    output logic [NBITS-1:0] o_cycle_cnt
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

`ifdef PIPELINE_SEQUENCER_WDOG_EN
    localparam int WW = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_LIMIT - 1);
    logic [WW-1:0] wdog_cnt;
`endif

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          raw_stall;
    logic          stall;
    logic          cmd_acc;
    logic          halt_seen;
    logic          in_drain;

    load_use_detector u_load_use (
        .i_id_rs     (i_id_rs),
        .i_id_rt     (i_id_rt),
        .i_ex_rt     (i_ex_rt),
        .i_ex_mem_rd (i_ex_mem_rd),
        .stall       (raw_stall)
    );

    assign in_drain          = (state == ST_DRAIN);
    assign o_pipe_en         = (state == ST_RUN) || (state == ST_STEP) || in_drain;
    assign o_cmd_ready       = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_HALTED);
    assign o_halted          = (state == ST_HALTED);
    assign o_state           = state;
    assign cmd_acc           = i_cmd_valid && o_cmd_ready;

    // Stall outranks flush, which outranks halt recognition.
    assign stall             = o_pipe_en && raw_stall;
    assign o_hazard_detected = stall;
    assign o_pc_en           = o_pipe_en && !stall && !in_drain;
    assign o_if_id_en        = o_pipe_en && !stall && !in_drain;
    assign o_if_id_flush     = o_pipe_en && !stall && !in_drain &&
                               (i_id_jump || i_id_branch_taken);
    assign halt_seen         = i_id_halt && !stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            drain_cnt   <= '0;
            o_cycle_cnt <= '0;
`ifdef PIPELINE_SEQUENCER_WDOG_EN
            wdog_cnt    <= '0;
            o_wdog_trip <= 1'b0;
`endif
        end else begin
            if (o_pipe_en && (o_cycle_cnt != '1))
                o_cycle_cnt <= o_cycle_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_acc && (i_cmd == CMD_RUN))
                        state <= ST_RUN;
                    else if (cmd_acc && (i_cmd == CMD_STEP))
                        state <= ST_STEP;
                end
                ST_RUN: begin
`ifdef PIPELINE_SEQUENCER_WDOG_EN
                    wdog_cnt <= wdog_cnt + 1'b1;
`endif
                    if (cmd_acc && (i_cmd == CMD_HALT_REQ)) begin
                        state <= ST_IDLE;
`ifdef PIPELINE_SEQUENCER_WDOG_EN
                        wdog_cnt <= '0;
`endif
                    end else if (halt_seen) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LAST;
`ifdef PIPELINE_SEQUENCER_WDOG_EN
                        wdog_cnt  <= '0;
                    end else if (wdog_cnt == WDOG_LAST) begin
                        state       <= ST_DRAIN;
                        drain_cnt   <= DRAIN_LAST;
                        wdog_cnt    <= '0;
                        o_wdog_trip <= 1'b1;
`endif
                    end
                end
                ST_STEP: begin
                    if (halt_seen) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LAST;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0)
                        state <= ST_HALTED;
                    else
                        drain_cnt <= drain_cnt - 1'b1;
                end
                ST_HALTED: begin
                    if (cmd_acc && (i_cmd == CMD_CLEAR)) begin
                        state       <= ST_IDLE;
                        o_cycle_cnt <= '0;
`ifdef PIPELINE_SEQUENCER_WDOG_EN
                        o_wdog_trip <= 1'b0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer; the cycle counter is built 4 bits wide so saturation is reachable.
module tb_pipeline_sequencer;
    import pipeline_sequencer_pkg::*;

    localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2, S_DRAIN = 3'd3, S_HALT = 3'd4;
    // flag order: pipe_en, pc_en, if_id_en, flush, hazard, halted, cmd_ready
    localparam logic [6:0] F_IDLE  = 7'b0000001;
    localparam logic [6:0] F_RUN   = 7'b1110001;
    localparam logic [6:0] F_STEP  = 7'b1110000;
    localparam logic [6:0] F_STALL = 7'b1000101;
    localparam logic [6:0] F_FLUSH = 7'b1111001;
    localparam logic [6:0] F_DRAIN = 7'b1000000;
    localparam logic [6:0] F_HALT  = 7'b0000011;

    logic       clk;
    logic       i_rst, i_cmd_valid, i_ex_mem_rd, i_id_jump, i_id_branch_taken, i_id_halt;
    logic [1:0] i_cmd;
    logic [4:0] i_id_rs, i_id_rt, i_ex_rt;
    logic       o_cmd_ready, o_pc_en, o_if_id_en, o_if_id_flush, o_hazard_detected, o_pipe_en, o_halted;
    logic [2:0] o_state;
    logic [3:0] o_cycle_cnt;
    logic       wdog_act;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [6:0] fl;
        logic [3:0] cnt;
        logic       wdog;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

`ifdef PIPELINE_SEQUENCER_WDOG_EN
    logic o_wdog_trip;
    assign wdog_act = o_wdog_trip;
`else
    assign wdog_act = 1'b0;
`endif

    pipeline_sequencer #(
        .NBITS(4)
`ifdef PIPELINE_SEQUENCER_WDOG_EN
        , .WDOG_LIMIT(10)
`endif
    ) dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_cmd_valid       (i_cmd_valid),
        .i_cmd             (i_cmd),
        .o_cmd_ready       (o_cmd_ready),
        .i_id_rs           (i_id_rs),
        .i_id_rt           (i_id_rt),
        .i_ex_rt           (i_ex_rt),
        .i_ex_mem_rd       (i_ex_mem_rd),
        .i_id_jump         (i_id_jump),
        .i_id_branch_taken (i_id_branch_taken),
        .i_id_halt         (i_id_halt),
        .o_pc_en           (o_pc_en),
        .o_if_id_en        (o_if_id_en),
        .o_if_id_flush     (o_if_id_flush),
        .o_hazard_detected (o_hazard_detected),
        .o_pipe_en         (o_pipe_en),
        .o_state           (o_state),
        .o_halted          (o_halted),
`ifdef PIPELINE_SEQUENCER_WDOG_EN
        .o_wdog_trip       (o_wdog_trip),
`endif
        .o_cycle_cnt       (o_cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs (just after a rising edge) and queue the outputs expected during it.
    task automatic vec(input string name, input logic rst, input logic cv, input logic [1:0] cmd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                       input logic ld, input logic jmp, input logic br, input logic hlt,
                       input logic [2:0] est, input logic [6:0] efl, input logic [3:0] ecnt,
                       input logic ew);
        exp_t e;
        i_rst = rst; i_cmd_valid = cv; i_cmd = cmd;
        i_id_rs = rs; i_id_rt = rt; i_ex_rt = ex_rt; i_ex_mem_rd = ld;
        i_id_jump = jmp; i_id_branch_taken = br; i_id_halt = hlt;
        e.name = name; e.st = est; e.fl = efl; e.cnt = ecnt; e.wdog = ew;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares on the falling edge, well away from the active edge.
    initial begin : monitor
        exp_t       e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {o_pipe_en, o_pc_en, o_if_id_en, o_if_id_flush, o_hazard_detected, o_halted, o_cmd_ready};
                n_vec++;
                if (o_state !== e.st || act !== e.fl || o_cycle_cnt !== e.cnt || wdog_act !== e.wdog) begin
                    n_err++;
                    $display("FAIL %s: got state=%0d flags=%b cnt=%0d wdog=%b, want state=%0d flags=%b cnt=%0d wdog=%b",
                             e.name, o_state, act, o_cycle_cnt, wdog_act, e.st, e.fl, e.cnt, e.wdog);
                end
            end
        end
    end

    initial begin : timeout
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = 2'b00;
        i_id_rs = '0; i_id_rt = '0; i_ex_rt = '0; i_ex_mem_rd = 1'b0;
        i_id_jump = 1'b0; i_id_branch_taken = 1'b0; i_id_halt = 1'b0;
        @(posedge clk);
        #1;
        //  name          rst cv cmd           rs rt ex ld j b h  state    flags    cnt w
        vec("reset",        1, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  0, 0);
        vec("step1_cmd",    0, 1, CMD_STEP,    0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  0, 0);
        vec("step1_pulse",  0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_STEP,  F_STEP,  0, 0);
        vec("step2_cmd",    0, 1, CMD_STEP,    0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  1, 0);
        vec("step2_pulse",  0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_STEP,  F_STEP,  1, 0);
        vec("step3_cmd",    0, 1, CMD_STEP,    0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  2, 0);
        vec("step3_ignore", 0, 1, CMD_RUN,     0, 0, 0, 0,0,0,0, S_STEP,  F_STEP,  2, 0);
        vec("idle_nostall", 0, 0, CMD_RUN,     5, 0, 5, 1,0,0,0, S_IDLE,  F_IDLE,  3, 0);
        vec("run_cmd",      0, 1, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  3, 0);
        vec("run_plain",    0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_RUN,   F_RUN,   3, 0);
        vec("stall_rs",     0, 0, CMD_RUN,     5, 0, 5, 1,0,0,0, S_RUN,   F_STALL, 4, 0);
        vec("r0_nostall",   0, 0, CMD_RUN,     0, 0, 0, 1,0,0,0, S_RUN,   F_RUN,   5, 0);
        vec("stall_rt",     0, 0, CMD_RUN,     3, 7, 7, 1,0,0,0, S_RUN,   F_STALL, 6, 0);
        vec("jump_flush",   0, 0, CMD_RUN,     0, 0, 0, 0,1,0,0, S_RUN,   F_FLUSH, 7, 0);
        vec("jump_stall",   0, 0, CMD_RUN,     5, 0, 5, 1,1,0,0, S_RUN,   F_STALL, 8, 0);
        vec("br_flush",     0, 0, CMD_RUN,     0, 0, 0, 0,0,1,0, S_RUN,   F_FLUSH, 9, 0);
        vec("halt_stalled", 0, 0, CMD_RUN,     5, 0, 5, 1,0,0,1, S_RUN,   F_STALL, 10, 0);
        vec("run_more",     0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_RUN,   F_RUN,   11, 0);
        vec("halt_seen",    0, 0, CMD_RUN,     0, 0, 0, 0,0,0,1, S_RUN,   F_RUN,   12, 0);
        vec("drain1",       0, 1, CMD_RUN,     0, 0, 0, 0,0,0,0, S_DRAIN, F_DRAIN, 13, 0);
        vec("drain2_jump",  0, 0, CMD_RUN,     0, 0, 0, 0,1,0,0, S_DRAIN, F_DRAIN, 14, 0);
        vec("drain3_sat",   0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_DRAIN, F_DRAIN, 15, 0);
        vec("halted_run",   0, 1, CMD_RUN,     0, 0, 0, 0,0,0,0, S_HALT,  F_HALT,  15, 0);
        vec("halted_hreq",  0, 1, CMD_HALT_REQ,0, 0, 0, 0,0,0,0, S_HALT,  F_HALT,  15, 0);
        vec("halted_clr",   0, 1, CMD_CLEAR,   0, 0, 0, 0,0,0,0, S_HALT,  F_HALT,  15, 0);
        vec("cleared",      0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  0, 0);
        vec("run2_cmd",     0, 1, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  0, 0);
        vec("run2_hreq",    0, 1, CMD_HALT_REQ,0, 0, 0, 0,0,0,0, S_RUN,   F_RUN,   0, 0);
        vec("hreq_idle",    0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  1, 0);
        vec("run3_cmd",     0, 1, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  1, 0);
        vec("run3_halt",    0, 0, CMD_RUN,     0, 0, 0, 0,0,0,1, S_RUN,   F_RUN,   1, 0);
        vec("rdrain1",      0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_DRAIN, F_DRAIN, 2, 0);
        vec("rst_in_drain", 1, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  0, 0);
        vec("post_rst",     0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  0, 0);
        vec("step_h_cmd",   0, 1, CMD_STEP,    0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  0, 0);
        vec("step_halt",    0, 0, CMD_RUN,     0, 0, 0, 0,0,0,1, S_STEP,  F_STEP,  0, 0);
        vec("sdrain1",      0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_DRAIN, F_DRAIN, 1, 0);
        vec("sdrain2",      0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_DRAIN, F_DRAIN, 2, 0);
        vec("sdrain3",      0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_DRAIN, F_DRAIN, 3, 0);
        vec("s_halted_clr", 0, 1, CMD_CLEAR,   0, 0, 0, 0,0,0,0, S_HALT,  F_HALT,  4, 0);
        vec("s_cleared",    0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  0, 0);
`ifdef PIPELINE_SEQUENCER_WDOG_EN
        vec("wd_run_cmd",   0, 1, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  0, 0);
        for (int k = 0; k < 10; k++)
            vec("wd_run",   0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_RUN,   F_RUN,   4'(k), 0);
        vec("wd_drain1",    0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_DRAIN, F_DRAIN, 10, 1);
        vec("wd_drain2",    0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_DRAIN, F_DRAIN, 11, 1);
        vec("wd_drain3",    0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_DRAIN, F_DRAIN, 12, 1);
        vec("wd_halted",    0, 1, CMD_RUN,     0, 0, 0, 0,0,0,0, S_HALT,  F_HALT,  13, 1);
        vec("wd_clr",       0, 1, CMD_CLEAR,   0, 0, 0, 0,0,0,0, S_HALT,  F_HALT,  13, 1);
        vec("wd_cleared",   0, 0, CMD_RUN,     0, 0, 0, 0,0,0,0, S_IDLE,  F_IDLE,  0, 0);
`endif
        i_cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Run/step/halt sequencer and hazard scheduler for the 5-stage MIPS pipeline.
- Takes commands from the debug unit, detects load-use hazards against the ID stage, and flushes IF/ID on taken jumps or branches.
- Drains the pipeline when a HALT instruction reaches ID.
- Drives the PC enable, the IF/ID enable and flush, the global pipe enable, and the i_hazard_detected input of the ID stage.

Parameters:
- NBITS, 32, width of the cycle counter.
- DRAIN_CYCLES, 3, cycles the pipe stays enabled after HALT is seen in ID, so that EX/MEM/WB retire.
- WDOG_LIMIT, 1000000, RUN cycles before a watchdog trip (only with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  debug command valid.
- i_cmd  in  2  command: 00 RUN, 01 STEP, 10 HALT_REQ, 11 CLEAR.
- o_cmd_ready  out  1  command accepted when i_cmd_valid && o_cmd_ready.
- i_id_rs  in  5  rs field of the instruction in ID.
- i_id_rt  in  5  rt field of the instruction in ID.
- i_ex_rt  in  5  destination rt of the instruction in EX.
- i_ex_mem_rd  in  1  the instruction in EX is a load.
- i_id_jump  in  1  jump decoded in ID.
- i_id_branch_taken  in  1  branch in ID resolved as taken.
- i_id_halt  in  1  HALT opcode in ID.
- o_pc_en  out  1  PC register enable.
- o_if_id_en  out  1  IF/ID register enable.
- o_if_id_flush  out  1  IF/ID loads a NOP on this cycle.
- o_hazard_detected  out  1  to the ID stage; zeroes the control signals going into ID/EX (bubble).
- o_pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- o_state  out  3  current FSM state, for debug readout.
- o_halted  out  1  high in HALTED.
- o_cycle_cnt  out  NBITS  number of cycles with o_pipe_en=1.
- o_wdog_trip  out  1  watchdog fired; present only with the optional feature.

Behaviour:
- Reset (async, i_rst=1):
  - State is IDLE; all counters are 0.
  - o_pipe_en, o_pc_en, o_if_id_en, o_if_id_flush, o_hazard_detected and o_halted are 0.
  - o_cmd_ready is 1, because ready is derived combinationally from the state.
  - Reset mid-RUN or mid-DRAIN aborts immediately with no drain.
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- IDLE:
  - Pipe frozen; o_cmd_ready=1.
  - RUN goes to RUN. STEP goes to STEP. HALT_REQ and CLEAR are accepted with no effect.
- RUN:
  - o_pipe_en=1.
  - o_cmd_ready=1, but only HALT_REQ acts: it goes to IDLE on the next edge.
  - i_id_halt with no stall goes to DRAIN.
- STEP:
  - Exactly one cycle with o_pipe_en=1, then back to IDLE.
  - i_id_halt with no stall during that cycle goes to DRAIN instead.
  - o_cmd_ready=0.
- DRAIN:
  - o_pipe_en=1, o_pc_en=0, o_if_id_en=0.
  - Runs for DRAIN_CYCLES cycles, counted by drain_cnt, then goes to HALTED.
  - o_cmd_ready=0.
- HALTED:
  - Pipe frozen; o_halted=1; o_cmd_ready=1.
  - Only CLEAR acts: it goes to IDLE and zeroes o_cycle_cnt. Other commands are accepted and ignored.
- Hazard (stall), combinational, qualified by o_pipe_en:
  - stall = i_ex_mem_rd && i_ex_rt != 0 && (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt).
  - When stall=1: o_pc_en=0, o_if_id_en=0, o_hazard_detected=1, and the rest of the pipe advances.
- Flush:
  - o_if_id_flush = o_pipe_en && !stall && (i_id_jump || i_id_branch_taken) && state != DRAIN.
- Enables outside DRAIN: o_pc_en = o_if_id_en = o_pipe_en && !stall.
- Priority: stall over flush over halt.
  - HALT is recognised only when the stall is clear.
  - A HALT in ID that is held by a stall is recognised on the first unstalled cycle.
- o_cycle_cnt:
  - Increments on each edge where o_pipe_en=1.
  - Saturates at all-ones; never wraps.
- Command handshake: a command is accepted only when i_cmd_valid=1 and o_cmd_ready=1, and acts on the next clock edge.

Optional Feature:
- Macro: PIPELINE_SEQUENCER_WDOG_EN.
- Defined:
  - A wdog counter counts RUN cycles and clears on leaving RUN.
  - When it reaches WDOG_LIMIT, the FSM goes to DRAIN and o_wdog_trip is set sticky.
  - CLEAR or reset clears o_wdog_trip.
- Undefined: no counter, and the o_wdog_trip port is absent.

Decomposition:
- Package pipeline_sequencer_pkg holds:
  - The state enum encodings.
  - The command encodings CMD_RUN, CMD_STEP, CMD_HALT_REQ, CMD_CLEAR.
  - The default for DRAIN_CYCLES.
- One sub-module, load_use_detector: purely combinational, taking i_id_rs, i_id_rt, i_ex_rt and i_ex_mem_rd and producing stall.

Test Plan:
- Reset then STEP ×3, no hazards → exactly 3 single-cycle o_pipe_en pulses; o_cycle_cnt=3; state IDLE after each.
- RUN, then a load into $5 in EX while ID has rs=5 → one cycle with o_pc_en=0, o_if_id_en=0, o_hazard_detected=1, o_pipe_en=1; same check with i_ex_rt=0 → no stall.
- RUN with i_id_jump=1 → o_if_id_flush=1 for one cycle; jump plus a simultaneous load-use stall → flush=0 and stall=1.
- RUN, assert i_id_halt → DRAIN for 3 cycles (o_pc_en=0, o_pipe_en=1) → HALTED with o_halted=1; RUN command → state unchanged; CLEAR → IDLE with o_cycle_cnt=0.
- i_rst pulsed in the 2nd DRAIN cycle → immediately IDLE with all enables 0, then clean operation afterwards.
- With PIPELINE_SEQUENCER_WDOG_EN and WDOG_LIMIT=10, RUN with no HALT → DRAIN entered after cycle 10, o_wdog_trip=1 and it stays set until CLEAR.
